register_file_rename: RTL and testbench
=======================================

// Module: register_file_rename
// PURPOSE
//  Architectural register file plus rename table, directly downstream of the reorder buffer.
//  Retires ROB_cmt_rf_* writes into x1..x31 and tracks the ROB id of the newest in-flight producer per register.
//  Resolves ID's two source operands: clean register value, or value/readiness fetched from the ROB by tag.
//  Clears all rename state on a mispredict flush.
// PARAMETERS
//  REG_NUM    32  architectural registers (x0 hardwired zero)
//  REG_WD     5   register index width
//  ROB_ID_WD  32  ROB id width; ids increase monotonically and are compared over full width
//  XLEN       32  data width
// PORTS
//  clk              in   1          clock, rising edge
//  rst              in   1          asynchronous, active-low reset
//  rdy              in   1          global enable; low = hold all state
//  jump_wrong_flag  in   1          ROB mispredict pulse; flush rename state
//  ID_inst_flag     in   1          ID dispatches an instruction this cycle
//  ID_inst_rd       in   REG_WD     destination of dispatched instruction
//  ID_rob_id        in   ROB_ID_WD  ROB id allocated to it (ROB_ava_id)
//  ID_rs1, ID_rs2   in   REG_WD     source register indices
//  RF_rs1_ready     out  1          rs1 value valid
//  RF_rs1_val       out  XLEN       rs1 value (meaningful when ready)
//  RF_rs1_rob_id    out  ROB_ID_WD  producer tag (meaningful when !ready)
//  RF_rs2_*         out  as rs1     same, for rs2
//  RF_id1, RF_id2   out  ROB_ID_WD  ROB query tags = tag[ID_rs1], tag[ID_rs2]
//  RF_id1_ready/RF_id2_ready  in  1      ROB entry ready
//  RF_id1_val/RF_id2_val      in  XLEN   ROB entry value
//  ROB_cmt_rf_flag  in   1          commit write valid
//  ROB_cmt_rf_rd    in   REG_WD     commit destination
//  ROB_cmt_rf_rob_id in  ROB_ID_WD  commit ROB id
//  ROB_cmt_rf_val   in   XLEN       commit value
// BEHAVIOUR
//  State: regs[REG_NUM], busy[REG_NUM], tag[REG_NUM]. rst low: all zero immediately; outputs follow combinationally (x0 ready, val 0).
//  Operand resolve (combinational, 0-cycle, priority order):
//   - rs==0 -> ready=1, val=0.
//   - !busy[rs] -> ready=1, val=regs[rs].
//   - commit this cycle with cmt_rob_id==tag[rs] -> ready=1, val=ROB_cmt_rf_val (bypass).
//   - RF_idN_ready -> ready=1, val=RF_idN_val.
//   - else ready=0, rob_id=tag[rs].
//   - Same-cycle rename of rs by ID does not affect its own operands (reads use pre-edge state).
//  Sequential, posedge clk when rst high and rdy high (rdy low: no update, inputs ignored):
//   - Commit: ROB_cmt_rf_flag && rd!=0 -> regs[rd]<=val; busy[rd]<=0 only if tag[rd]==cmt_rob_id.
//   - Rename: ID_inst_flag && rd!=0 && !jump_wrong_flag -> busy[rd]<=1, tag[rd]<=ID_rob_id.
//   - Commit and rename same rd same cycle: value written, rename wins (busy=1, new tag).
//   - jump_wrong_flag: busy<=0 for all regs; tags kept; concurrent commit (JAL/JALR rd) still writes regs.
//   - Writes to x0 dropped everywhere; busy[0] never set.
// STRUCTURE
//  Def.v: `True/`False, `ZERO_REG, XLEN/ROB id widths.
//  Sub-module rf_operand_lookup: combinational per-operand resolver; instantiated twice.
// TESTING
//  Reset: rst low mid-run with busy regs -> all busy clear, rs1=5 reads ready, val 0.
//  Rename x5 id 7, read rs1=5 next cycle, ROB not ready -> ready=0, rob_id=7, RF_id1=7.
//  Commit x5 id 7 val 0xAB with rs1=5 same cycle -> ready=1 val 0xAB bypass; next cycle busy clear.
//  Rename x5 id 7 then id 9; commit id 7 val 1 -> regs[5]=1, still busy tag 9.
//  Commit x5 id 9 and rename x5 id 12 same cycle -> regs[5] updated, busy, tag 12.
//  Busy x3,x8 then jump_wrong_flag with commit x1 val 0x100 -> all ready, regs[1]=0x100; rename to x0 ignored.

Source files
------------

// File: rtl/register_file_rename_pkg.sv
// Shared widths, index/data types and helpers for the register file with rename table.
package register_file_rename_pkg;

    localparam int unsigned REG_NUM   = 32;
    localparam int unsigned REG_WD    = 5;
    localparam int unsigned ROB_ID_WD = 32;
    localparam int unsigned XLEN      = 32;

    typedef logic [REG_WD-1:0]    reg_idx_t;
    typedef logic [ROB_ID_WD-1:0] rob_id_t;
    typedef logic [XLEN-1:0]      xlen_t;

    localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/register_file_rename_lookup.sv
// Combinational resolver for one source operand: zero reg, clean value, commit bypass,
// ROB-supplied value, or an outstanding producer tag.
module register_file_rename_lookup
    import register_file_rename_pkg::*;
(
    input  reg_idx_t rs,
    input  logic     busy,
    input  xlen_t    reg_val,
    input  rob_id_t  tag,
    input  logic     cmt_flag,
    input  rob_id_t  cmt_rob_id,
    input  xlen_t    cmt_val,
    input  logic     rob_ready,
    input  xlen_t    rob_val,
    output logic     ready,
    output xlen_t    val,
    output rob_id_t  rob_id
);

    always_comb begin
        ready  = 1'b0;
        val    = '0;
        rob_id = tag;
        if (rs == ZERO_REG) begin
            ready = 1'b1;
        end else if (!busy) begin
            ready = 1'b1;
            val   = reg_val;
        end else if (cmt_flag && (cmt_rob_id == tag)) begin
            // Producer retires this very cycle; forward instead of waiting an edge.
            ready = 1'b1;
            val   = cmt_val;
        end else if (rob_ready) begin
            ready = 1'b1;
            val   = rob_val;
        end
    end

endmodule

// File: rtl/register_file_rename.sv
// Architectural register file plus rename table: retires ROB commits, tracks the newest
// in-flight producer per register and resolves the two ID source operands.
module register_file_rename
    import register_file_rename_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    input  logic     jump_wrong_flag,
    input  logic     ID_inst_flag,
    input  reg_idx_t ID_inst_rd,
    input  rob_id_t  ID_rob_id,
    input  reg_idx_t ID_rs1,
    input  reg_idx_t ID_rs2,
    output logic     RF_rs1_ready,
    output xlen_t    RF_rs1_val,
    output rob_id_t  RF_rs1_rob_id,
    output logic     RF_rs2_ready,
    output xlen_t    RF_rs2_val,
    output rob_id_t  RF_rs2_rob_id,
    output rob_id_t  RF_id1,
    output rob_id_t  RF_id2,
    input  logic     RF_id1_ready,
    input  logic     RF_id2_ready,
    input  xlen_t    RF_id1_val,
    input  xlen_t    RF_id2_val,
    input  logic     ROB_cmt_rf_flag,
    input  reg_idx_t ROB_cmt_rf_rd,
    input  rob_id_t  ROB_cmt_rf_rob_id,
    input  xlen_t    ROB_cmt_rf_val
);

    xlen_t              regs_q [REG_NUM];
    xlen_t              regs_d [REG_NUM];
    rob_id_t            tag_q  [REG_NUM];
    rob_id_t            tag_d  [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

    always_comb begin
        regs_d = regs_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (ROB_cmt_rf_flag && (ROB_cmt_rf_rd != ZERO_REG)) begin
            regs_d[ROB_cmt_rf_rd] = ROB_cmt_rf_val;
            // Only the newest producer may clear busy; older commits just update the value.
            if (tag_q[ROB_cmt_rf_rd] == ROB_cmt_rf_rob_id) begin
                busy_d[ROB_cmt_rf_rd] = 1'b0;
            end
        end
        if (jump_wrong_flag) begin
            busy_d = '0;
        end else if (ID_inst_flag && (ID_inst_rd != ZERO_REG)) begin
            busy_d[ID_inst_rd] = 1'b1;
            tag_d[ID_inst_rd]  = ID_rob_id;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                regs_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            busy_q <= '0;
        end else if (rdy) begin
            regs_q <= regs_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
        end
    end

    assign RF_id1 = tag_q[ID_rs1];
    assign RF_id2 = tag_q[ID_rs2];

    register_file_rename_lookup u_lookup_rs1 (
        .rs         (ID_rs1),
        .busy       (busy_q[ID_rs1]),
        .reg_val    (regs_q[ID_rs1]),
        .tag        (tag_q[ID_rs1]),
        .cmt_flag   (ROB_cmt_rf_flag),
        .cmt_rob_id (ROB_cmt_rf_rob_id),
        .cmt_val    (ROB_cmt_rf_val),
        .rob_ready  (RF_id1_ready),
        .rob_val    (RF_id1_val),
        .ready      (RF_rs1_ready),
        .val        (RF_rs1_val),
        .rob_id     (RF_rs1_rob_id)
    );

    register_file_rename_lookup u_lookup_rs2 (
        .rs         (ID_rs2),
        .busy       (busy_q[ID_rs2]),
        .reg_val    (regs_q[ID_rs2]),
        .tag        (tag_q[ID_rs2]),
        .cmt_flag   (ROB_cmt_rf_flag),
        .cmt_rob_id (ROB_cmt_rf_rob_id),
        .cmt_val    (ROB_cmt_rf_val),
        .rob_ready  (RF_id2_ready),
        .rob_val    (RF_id2_val),
        .ready      (RF_rs2_ready),
        .val        (RF_rs2_val),
        .rob_id     (RF_rs2_rob_id)
    );

endmodule

// File: tb/tb_register_file_rename.sv
// Randomized bench for register_file_rename against an array-based reference model,
// plus directed scenarios with literal expectations.
module tb_register_file_rename;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        jump_wrong_flag;
    logic        ID_inst_flag;
    logic [4:0]  ID_inst_rd;
    logic [31:0] ID_rob_id;
    logic [4:0]  ID_rs1;
    logic [4:0]  ID_rs2;
    logic        RF_rs1_ready;
    logic [31:0] RF_rs1_val;
    logic [31:0] RF_rs1_rob_id;
    logic        RF_rs2_ready;
    logic [31:0] RF_rs2_val;
    logic [31:0] RF_rs2_rob_id;
    logic [31:0] RF_id1;
    logic [31:0] RF_id2;
    logic        RF_id1_ready;
    logic        RF_id2_ready;
    logic [31:0] RF_id1_val;
    logic [31:0] RF_id2_val;
    logic        ROB_cmt_rf_flag;
    logic [4:0]  ROB_cmt_rf_rd;
    logic [31:0] ROB_cmt_rf_rob_id;
    logic [31:0] ROB_cmt_rf_val;

    register_file_rename dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .jump_wrong_flag   (jump_wrong_flag),
        .ID_inst_flag      (ID_inst_flag),
        .ID_inst_rd        (ID_inst_rd),
        .ID_rob_id         (ID_rob_id),
        .ID_rs1            (ID_rs1),
        .ID_rs2            (ID_rs2),
        .RF_rs1_ready      (RF_rs1_ready),
        .RF_rs1_val        (RF_rs1_val),
        .RF_rs1_rob_id     (RF_rs1_rob_id),
        .RF_rs2_ready      (RF_rs2_ready),
        .RF_rs2_val        (RF_rs2_val),
        .RF_rs2_rob_id     (RF_rs2_rob_id),
        .RF_id1            (RF_id1),
        .RF_id2            (RF_id2),
        .RF_id1_ready      (RF_id1_ready),
        .RF_id2_ready      (RF_id2_ready),
        .RF_id1_val        (RF_id1_val),
        .RF_id2_val        (RF_id2_val),
        .ROB_cmt_rf_flag   (ROB_cmt_rf_flag),
        .ROB_cmt_rf_rd     (ROB_cmt_rf_rd),
        .ROB_cmt_rf_rob_id (ROB_cmt_rf_rob_id),
        .ROB_cmt_rf_val    (ROB_cmt_rf_val)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_regs [32];
    logic        m_busy [32];
    logic [31:0] m_tag  [32];

    int checks   = 0;
    int failures = 0;
    logic [31:0] next_id = 32'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    task automatic model_clock();
        logic clr;
        if (!(rst && rdy)) return;
        clr = 1'b0;
        if (ROB_cmt_rf_flag && ROB_cmt_rf_rd != 0) begin
            clr = (m_tag[ROB_cmt_rf_rd] == ROB_cmt_rf_rob_id);
            m_regs[ROB_cmt_rf_rd] = ROB_cmt_rf_val;
            if (clr) m_busy[ROB_cmt_rf_rd] = 1'b0;
        end
        if (jump_wrong_flag) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else if (ID_inst_flag && ID_inst_rd != 0) begin
            m_busy[ID_inst_rd] = 1'b1;
            m_tag[ID_inst_rd]  = ID_rob_id;
        end
    endtask

    task automatic expect_operand(input logic [4:0] rs, input logic rob_rdy,
                                  input logic [31:0] rob_v, output logic e_rdy,
                                  output logic [31:0] e_val);
        e_rdy = 1'b1;
        e_val = '0;
        if (rs == 0) e_val = '0;
        else if (!m_busy[rs]) e_val = m_regs[rs];
        else if (ROB_cmt_rf_flag && ROB_cmt_rf_rob_id == m_tag[rs]) e_val = ROB_cmt_rf_val;
        else if (rob_rdy) e_val = rob_v;
        else e_rdy = 1'b0;
    endtask

    // Compare all operand outputs against the model for the currently applied inputs.
    task automatic check_model();
        logic        r1, r2;
        logic [31:0] v1, v2;
        expect_operand(ID_rs1, RF_id1_ready, RF_id1_val, r1, v1);
        expect_operand(ID_rs2, RF_id2_ready, RF_id2_val, r2, v2);
        chk("rs1_ready", {31'd0, RF_rs1_ready}, {31'd0, r1});
        chk("rs2_ready", {31'd0, RF_rs2_ready}, {31'd0, r2});
        if (r1) chk("rs1_val", RF_rs1_val, v1);
        else    chk("rs1_rob_id", RF_rs1_rob_id, m_tag[ID_rs1]);
        if (r2) chk("rs2_val", RF_rs2_val, v2);
        else    chk("rs2_rob_id", RF_rs2_rob_id, m_tag[ID_rs2]);
        chk("RF_id1", RF_id1, m_tag[ID_rs1]);
        chk("RF_id2", RF_id2, m_tag[ID_rs2]);
    endtask

    task automatic idle_inputs();
        rdy               = 1'b1;
        jump_wrong_flag   = 1'b0;
        ID_inst_flag      = 1'b0;
        ID_inst_rd        = '0;
        ID_rob_id         = '0;
        ID_rs1            = '0;
        ID_rs2            = '0;
        RF_id1_ready      = 1'b0;
        RF_id2_ready      = 1'b0;
        RF_id1_val        = '0;
        RF_id2_val        = '0;
        ROB_cmt_rf_flag   = 1'b0;
        ROB_cmt_rf_rd     = '0;
        ROB_cmt_rf_rob_id = '0;
        ROB_cmt_rf_val    = '0;
    endtask

    // Inputs are stable from the previous negedge; update model at the edge, return at negedge.
    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic rename(input logic [4:0] rd, input logic [31:0] id);
        idle_inputs();
        ID_inst_flag = 1'b1;
        ID_inst_rd   = rd;
        ID_rob_id    = id;
        #1 check_model();
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        model_reset();
        #1;
        ID_rs1 = 5'd5;
        #1 check_model();
        chk("reset_rs1_ready", {31'd0, RF_rs1_ready}, 32'd1);
        chk("reset_rs1_val", RF_rs1_val, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Rename x5 -> id 7, ROB not ready: operand waits on tag 7
        rename(5'd5, 32'd7);
        idle_inputs();
        ID_rs1 = 5'd5;
        #1 check_model();
        chk("ren_ready", {31'd0, RF_rs1_ready}, 32'd0);
        chk("ren_rob_id", RF_rs1_rob_id, 32'd7);
        chk("ren_id1", RF_id1, 32'd7);
        // Same tag with ROB ready forwards the ROB value
        RF_id1_ready = 1'b1;
        RF_id1_val   = 32'h1234;
        #1 chk("rob_fwd_val", RF_rs1_val, 32'h1234);

        // Commit bypass then clean read
        idle_inputs();
        ID_rs1            = 5'd5;
        ROB_cmt_rf_flag   = 1'b1;
        ROB_cmt_rf_rd     = 5'd5;
        ROB_cmt_rf_rob_id = 32'd7;
        ROB_cmt_rf_val    = 32'hAB;
        #1 check_model();
        chk("bypass_ready", {31'd0, RF_rs1_ready}, 32'd1);
        chk("bypass_val", RF_rs1_val, 32'hAB);
        tick();
        idle_inputs();
        ID_rs1 = 5'd5;
        #1 check_model();
        chk("post_cmt_ready", {31'd0, RF_rs1_ready}, 32'd1);
        chk("post_cmt_val", RF_rs1_val, 32'hAB);

        // Older commit updates the value but leaves newer producer busy
        rename(5'd5, 32'd7);
        rename(5'd5, 32'd9);
        idle_inputs();
        ROB_cmt_rf_flag   = 1'b1;
        ROB_cmt_rf_rd     = 5'd5;
        ROB_cmt_rf_rob_id = 32'd7;
        ROB_cmt_rf_val    = 32'd1;
        #1 check_model();
        tick();
        idle_inputs();
        ID_rs1 = 5'd5;
        #1 check_model();
        chk("old_cmt_ready", {31'd0, RF_rs1_ready}, 32'd0);
        chk("old_cmt_tag", RF_rs1_rob_id, 32'd9);

        // Commit id 9 and rename id 12 on x5 in one cycle: rename wins
        ROB_cmt_rf_flag   = 1'b1;
        ROB_cmt_rf_rd     = 5'd5;
        ROB_cmt_rf_rob_id = 32'd9;
        ROB_cmt_rf_val    = 32'h55;
        ID_inst_flag      = 1'b1;
        ID_inst_rd        = 5'd5;
        ID_rob_id         = 32'd12;
        ID_rs1            = 5'd0;
        #1 check_model();
        tick();
        idle_inputs();
        ID_rs1 = 5'd5;
        #1 check_model();
        chk("cmt_ren_ready", {31'd0, RF_rs1_ready}, 32'd0);
        chk("cmt_ren_tag", RF_rs1_rob_id, 32'd12);

        // Flush with concurrent commit to x1; dispatch in the flush cycle is dropped
        rename(5'd3, 32'd20);
        rename(5'd8, 32'd21);
        idle_inputs();
        jump_wrong_flag   = 1'b1;
        ROB_cmt_rf_flag   = 1'b1;
        ROB_cmt_rf_rd     = 5'd1;
        ROB_cmt_rf_rob_id = 32'd22;
        ROB_cmt_rf_val    = 32'h100;
        ID_inst_flag      = 1'b1;
        ID_inst_rd        = 5'd4;
        ID_rob_id         = 32'd23;
        #1 check_model();
        tick();
        rename(5'd0, 32'd30);
        idle_inputs();
        ID_rs1 = 5'd3;
        ID_rs2 = 5'd8;
        #1 check_model();
        chk("flush_x3", {31'd0, RF_rs1_ready}, 32'd1);
        chk("flush_x8", {31'd0, RF_rs2_ready}, 32'd1);
        ID_rs1 = 5'd1;
        ID_rs2 = 5'd0;
        #1 check_model();
        chk("flush_x1_val", RF_rs1_val, 32'h100);
        chk("x0_ready", {31'd0, RF_rs2_ready}, 32'd1);
        chk("x0_val", RF_rs2_val, 32'd0);
        ID_rs1 = 5'd5;
        ID_rs2 = 5'd4;
        #1 check_model();
        chk("flush_x5_val", RF_rs1_val, 32'h55);
        chk("flush_x4_ready", {31'd0, RF_rs2_ready}, 32'd1);

        // rdy low: dispatch ignored
        idle_inputs();
        rdy          = 1'b0;
        ID_inst_flag = 1'b1;
        ID_inst_rd   = 5'd6;
        ID_rob_id    = 32'd40;
        tick();
        idle_inputs();
        ID_rs1 = 5'd6;
        #1 check_model();
        chk("hold_ready", {31'd0, RF_rs1_ready}, 32'd1);

        // Randomized phase
        next_id = 32'd100;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [4:0] crd;
            idle_inputs();
            rdy             = ($urandom_range(9) != 0);
            jump_wrong_flag = ($urandom_range(24) == 0);
            ID_inst_flag    = $urandom_range(1);
            ID_inst_rd      = 5'($urandom_range(7));
            ID_rob_id       = next_id;
            if (ID_inst_flag && rdy && !jump_wrong_flag) next_id = next_id + 1;
            ID_rs1          = ($urandom_range(7) == 0) ? 5'($urandom) : 5'($urandom_range(7));
            ID_rs2          = ($urandom_range(7) == 0) ? 5'($urandom) : 5'($urandom_range(7));
            RF_id1_ready    = ($urandom_range(3) == 0);
            RF_id2_ready    = ($urandom_range(3) == 0);
            RF_id1_val      = $urandom;
            RF_id2_val      = $urandom;
            ROB_cmt_rf_flag = $urandom_range(1);
            crd             = 5'($urandom_range(7));
            ROB_cmt_rf_rd   = crd;
            ROB_cmt_rf_rob_id = $urandom_range(1) ? m_tag[crd] : next_id - $urandom_range(20);
            ROB_cmt_rf_val  = $urandom;
            #1 check_model();
            if (cyc == 1500) begin
                // Asynchronous reset mid-cycle while registers are busy
                rename(5'd5, next_id);
                next_id = next_id + 1;
                idle_inputs();
                ID_rs1 = 5'd5;
                #2 rst = 1'b0;
                model_reset();
                #1 check_model();
                chk("midrst_ready", {31'd0, RF_rs1_ready}, 32'd1);
                chk("midrst_val", RF_rs1_val, 32'd0);
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
            end else begin
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
